// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle main controller and its MIPS datapath.
// slave = controller side, master = datapath (or bench) side.
interface multicycle_ctrl_if #(
    parameter int COUNT_WIDTH = 32
);
    logic [5:0]             opcode;
    logic                   zero;
    logic                   mem_ready;
    logic                   pc_en;
    logic                   iord;
    logic                   memread;
    logic                   memwrite;
    logic                   irwrite;
    logic                   memtoreg;
    logic                   regdst;
    logic                   regwrite;
    logic                   alusrca;
    logic [1:0]             alusrcb;
    logic [1:0]             aluop;
    logic [1:0]             pcsource;
    logic [3:0]             state;
    logic                   illegal_op;
    logic [COUNT_WIDTH-1:0] instr_count;

    modport master (
        output opcode, zero, mem_ready,
        input  pc_en, iord, memread, memwrite, irwrite,
        input  memtoreg, regdst, regwrite, alusrca,
        input  alusrcb, aluop, pcsource,
        input  state, illegal_op, instr_count
    );

    modport slave (
        input  opcode, zero, mem_ready,
        output pc_en, iord, memread, memwrite, irwrite,
        output memtoreg, regdst, regwrite, alusrca,
        output alusrcb, aluop, pcsource,
        output state, illegal_op, instr_count
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main controller for a word-addressed multicycle MIPS datapath:
// 3-5 states per instruction, memory states stall on mem_ready.
module multicycle_ctrl #(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int COUNT_WIDTH = 32
) (
    input logic            clk,
    input logic            reset,
    multicycle_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    typedef struct packed {
        logic       jump_en;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
    } ctrl_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    state_t                 state_q;
    state_t                 nxt;
    ctrl_t                  ctrl_q;
    logic [5:0]             op_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   illegal_q;
    logic                   retire;
    logic                   bad;
    logic                   rdy;
    logic                   br_take;
    logic                   in_fetch;
    logic                   in_branch;
    logic                   op_mem;
    logic                   op_br;

    // Moore part of the outputs, looked up per state and registered
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.memread = 1'b1;
                c.alusrcb = 2'b01;
            end
            DECODE: c.alusrcb = 2'b11;
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            MEMRD: begin
                c.iord    = 1'b1;
                c.memread = 1'b1;
            end
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            EXEC: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            BRANCH: begin
                c.alusrca  = 1'b1;
                c.aluop    = 2'b01;
                c.pcsource = 2'b01;
            end
            ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            ADDIWB: c.regwrite = 1'b1;
            JUMP: begin
                c.pcsource = 2'b10;
                c.jump_en  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign rdy    = MEM_WAIT_EN ? bus.mem_ready : 1'b1;
    assign op_mem = (bus.opcode == OP_LW) || (bus.opcode == OP_SW);
    assign op_br  = (bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE);

    always_comb begin
        nxt    = FETCH;
        retire = 1'b0;
        bad    = 1'b0;
        case (state_q)
            FETCH:  nxt = rdy ? DECODE : FETCH;
            DECODE: begin
                unique case (1'b1)
                    op_mem:                   nxt = MEMADR;
                    (bus.opcode == OP_R):     nxt = EXEC;
                    op_br:                    nxt = BRANCH;
                    (bus.opcode == OP_ADDI):  nxt = ADDIEX;
                    (bus.opcode == OP_J):     nxt = JUMP;
                    default:                  bad = 1'b1;
                endcase
            end
            MEMADR: nxt = (op_q == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  nxt = rdy ? MEMWB : MEMRD;
            MEMWR: begin
                nxt    = rdy ? FETCH : MEMWR;
                retire = rdy;
            end
            EXEC:   nxt = ALUWB;
            ADDIEX: nxt = ADDIWB;
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: retire = 1'b1;
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            ctrl_q    <= ctrl_of(FETCH);
            op_q      <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= nxt;
            ctrl_q  <= ctrl_of(nxt);
            if (state_q == DECODE)
                op_q <= bus.opcode;
            if (retire)
                count_q <= count_q + COUNT_WIDTH'(1);
            if (bad)
                illegal_q <= 1'b1;
        end
    end

    // Mealy terms: fetch completes on mem_ready, branch decides on zero
    assign in_fetch  = (state_q == FETCH);
    assign in_branch = (state_q == BRANCH);
    assign br_take   = (op_q == OP_BEQ) ? bus.zero : ~bus.zero;

    assign bus.pc_en    = ~reset & (ctrl_q.jump_en
                        | (in_fetch & rdy)
                        | (in_branch & br_take));
    assign bus.irwrite  = ~reset & in_fetch & rdy;
    assign bus.iord     = ~reset & ctrl_q.iord;
    assign bus.memread  = ~reset & ctrl_q.memread;
    assign bus.memwrite = ~reset & ctrl_q.memwrite;
    assign bus.memtoreg = ~reset & ctrl_q.memtoreg;
    assign bus.regdst   = ~reset & ctrl_q.regdst;
    assign bus.regwrite = ~reset & ctrl_q.regwrite;
    assign bus.alusrca  = ~reset & ctrl_q.alusrca;
    assign bus.alusrcb  = {2{~reset}} & ctrl_q.alusrcb;
    assign bus.aluop    = {2{~reset}} & ctrl_q.aluop;
    assign bus.pcsource = {2{~reset}} & ctrl_q.pcsource;

    assign bus.state       = state_q;
    assign bus.illegal_op  = illegal_q;
    assign bus.instr_count = count_q;
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style main controller that sequences a multicycle MIPS datapath: IR, PC, shared instruction/data memory, register file and ALU.
- It replaces the single-cycle combinational control and branch-select glue.
- Each instruction takes 3-5 states; memory states stall on a ready handshake.
- It also provides a retired-instruction counter and a sticky illegal-opcode flag for the bench.

Parameters:
- MEM_WAIT_EN, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored (treated as 1).
- COUNT_WIDTH, 32, width of instr_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- pc_en  out  1  PC load enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memread  out  1  memory read strobe.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  IR load enable.
- memtoreg  out  1  write-back select: 1 = MDR, 0 = ALUOut.
- regdst  out  1  destination register: 1 = rd, 0 = rt.
- regwrite  out  1  register file write enable.
- alusrca  out  1  ALU A: 0 = PC, 1 = rs.
- alusrcb  out  2  ALU B: 00 = rt, 01 = constant 1, 10 = sign-extended imm, 11 = sign-extended imm (branch target).
- aluop  out  2  to ALU control: 00 = add, 01 = sub, 10 = funct.
- pcsource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state code, for debug.
- illegal_op  out  1  sticky: an unsupported opcode was decoded.
- instr_count  out  COUNT_WIDTH  number of retired instructions.

Behaviour:
- PC is word-addressed: increment is +1 and branch offsets are not shifted.
- State codes:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11
  - Codes 12-15 are unreachable; if entered, go to FETCH.
- Reset:
  - While reset=1 at a clock edge: state<=FETCH, instr_count<=0, illegal_op<=0, latched opcode<=0.
  - While reset=1, all control outputs are forced to 0.
  - A reset asserted in any state aborts the instruction; no partial write is issued after that edge.
- Outputs default to 0 unless listed for the current state:
  - FETCH: memread=1, alusrcb=01. irwrite=pc_en=mem_ready (Mealy), so PC increments exactly once. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE: alusrcb=11; latch opcode. Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXEC
    - 000100 (beq) or 000101 (bne) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - any other -> FETCH, set illegal_op=1; instr_count is not incremented.
  - MEMADR: alusrca=1, alusrcb=10. Next MEMRD if lw, MEMWR if sw.
  - MEMRD: iord=1, memread=1. Stay until mem_ready=1, then MEMWB.
  - MEMWB: memtoreg=1, regwrite=1, regdst=0. Next FETCH.
  - MEMWR: iord=1, memwrite=1. Stay until mem_ready=1, then FETCH.
  - EXEC: alusrca=1, aluop=10. Next ALUWB.
  - ALUWB: regdst=1, regwrite=1. Next FETCH.
  - BRANCH: alusrca=1, aluop=01, pcsource=01. pc_en=zero for latched beq, pc_en=~zero for bne (combinational on zero). Next FETCH.
  - ADDIEX: alusrca=1, alusrcb=10. Next ADDIWB.
  - ADDIWB: regwrite=1, regdst=0. Next FETCH.
  - JUMP: pcsource=10, pc_en=1. Next FETCH.
- Instruction counter:
  - instr_count increments by 1 on each edge leaving MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH, ADDIWB or JUMP to FETCH.
  - Wraps modulo 2^COUNT_WIDTH.
- Memory handshake:
  - memread/memwrite stay asserted for the whole wait.
  - memwrite is asserted only in MEMWR, never in the same cycle as memread.
- Cycle counts with mem_ready held at 1:
  - lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3.
- illegal_op is cleared only by reset.

Test Plan:
- reset=1 for 2 cycles, then lw (opcode 100011) with mem_ready=1 → state sequence 0,1,2,3,4,0; regwrite=1 only in state 4; instr_count=1.
- sw with mem_ready=0 for 3 cycles in MEMWR → memwrite=1 for 4 cycles; leave to FETCH on the ready cycle; no regwrite.
- beq (000100) with zero=1 → pc_en=1, pcsource=01 in BRANCH. Repeat with bne (000101) and zero=1 → pc_en=0.
- Fetch with mem_ready low for 2 cycles → pc_en and irwrite each high exactly 1 cycle. R-type, then addi → 4 cycles each; instr_count=2.
- opcode 111111 → DECODE to FETCH; illegal_op=1 and stays high; instr_count unchanged.
- Reset asserted in MEMRD, and separately MEM_WAIT_EN=0 run → FETCH and outputs 0 the next cycle; count=0. With MEM_WAIT_EN=0, lw completes in 5 cycles with mem_ready tied to 0.
